// File: rtl/moedeiro_if.sv
// Coin acceptor bus: coin sensors, cancel and busy in;
// start pulse, credit, change and refusal out.
interface moedeiro_if;
  logic       botao_50cent;
  logic       botao_1real;
  logic       cancelar;
  logic       ocupado;
  logic       moeda;
  logic [3:0] credito;
  logic       devolve;
  logic       rejeita;

  modport master (
    output botao_50cent, botao_1real, cancelar, ocupado,
    input  moeda, credito, devolve, rejeita
  );

  modport slave (
    input  botao_50cent, botao_1real, cancelar, ocupado,
    output moeda, credito, devolve, rejeita
  );
endinterface

// File: rtl/moedeiro.sv
// Coin acceptor for a laundry washer: accumulates credit,
// starts the wash at the price, returns change or refunds.
module moedeiro #(
  parameter int unsigned PRECO       = 4,
  parameter int unsigned CREDITO_MAX = 8
) (
  input logic       clk,
  input logic       reset,
  moedeiro_if.slave bus
);

  typedef enum logic [2:0] {
    OCIOSO, ACUMULA, LIBERA, TROCO, OCUPADO
  } estado_t;

  localparam logic [4:0] PRECO5 = 5'(PRECO);
  localparam logic [4:0] MAX5   = 5'(CREDITO_MAX);

  estado_t    estado_q, estado_d;
  logic [3:0] credito_q, credito_d;
  logic [3:0] troco_q, troco_d;
  logic       pago_q, pago_d;
  logic       rej_q, rej_d;
  logic       p50_q, p1r_q;

  logic       e50, e1r, coin;
  logic [4:0] add, soma, cred5;

  assign e50   = bus.botao_50cent & ~p50_q;
  assign e1r   = bus.botao_1real & ~p1r_q;
  assign coin  = e50 | e1r;
  // 1 real weighs two units, so the edge pair is the sum
  assign add   = {3'b000, e1r, e50};
  assign cred5 = {1'b0, credito_q};
  assign soma  = cred5 + add;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= OCIOSO;
      credito_q <= '0;
      troco_q   <= '0;
      pago_q    <= 1'b0;
      rej_q     <= 1'b0;
      p50_q     <= 1'b1;
      p1r_q     <= 1'b1;
    end else begin
      estado_q  <= estado_d;
      credito_q <= credito_d;
      troco_q   <= troco_d;
      pago_q    <= pago_d;
      rej_q     <= rej_d;
      p50_q     <= bus.botao_50cent;
      p1r_q     <= bus.botao_1real;
    end
  end

  always_comb begin
    estado_d  = estado_q;
    credito_d = credito_q;
    troco_d   = troco_q;
    pago_d    = pago_q;
    rej_d     = 1'b0;
    unique case (estado_q)
      OCIOSO, ACUMULA: begin
        if (estado_q == ACUMULA && bus.cancelar) begin
          troco_d   = credito_q;
          credito_d = '0;
          pago_d    = 1'b0;
          rej_d     = coin;
          estado_d  = TROCO;
        end else if (coin) begin
          if (soma <= MAX5) begin
            credito_d = soma[3:0];
            estado_d  = (soma >= PRECO5) ? LIBERA : ACUMULA;
          end else begin
            rej_d = 1'b1;
          end
        end
      end
      LIBERA: begin
        rej_d     = coin;
        troco_d   = 4'(cred5 - PRECO5);
        credito_d = '0;
        pago_d    = 1'b1;
        estado_d  = (cred5 > PRECO5) ? TROCO : OCUPADO;
      end
      TROCO: begin
        rej_d   = coin;
        troco_d = troco_q - 4'd1;
        if (troco_q <= 4'd1)
          estado_d = pago_q ? OCUPADO : OCIOSO;
      end
      OCUPADO: begin
        rej_d = coin;
        if (!bus.ocupado)
          estado_d = OCIOSO;
      end
      default: estado_d = OCIOSO;
    endcase
  end

  assign bus.moeda   = (estado_q == LIBERA);
  assign bus.devolve = (estado_q == TROCO);
  assign bus.credito = credito_q;
  assign bus.rejeita = rej_q;

endmodule

// File: tb/tb_moedeiro.sv
// Randomized coin sessions checked against a session-level
// model of credit, payment, change, refund and refusals.
module tb_moedeiro;

  logic clk = 1'b0;
  logic reset;
  logic b50, b1r, canc, ocup;

  always #5 clk = ~clk;

  moedeiro_if bus_a ();
  moedeiro_if bus_b ();

  assign bus_a.botao_50cent = b50;
  assign bus_a.botao_1real  = b1r;
  assign bus_a.cancelar     = canc;
  assign bus_a.ocupado      = ocup;
  assign bus_b.botao_50cent = b50;
  assign bus_b.botao_1real  = b1r;
  assign bus_b.cancelar     = canc;
  assign bus_b.ocupado      = ocup;

  moedeiro #(.PRECO(4), .CREDITO_MAX(8)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a.slave)
  );

  moedeiro #(.PRECO(8), .CREDITO_MAX(8)) u_dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b.slave)
  );

  int n_chk = 0;
  int n_fail = 0;
  int mo_n, dv_n, dv_runs, rj_n;
  logic dv_prev = 1'b0;
  int credit, exp_rej;
  int ops[$];

  always @(negedge clk) begin
    if (bus_a.moeda) mo_n++;
    if (bus_a.devolve) dv_n++;
    if (bus_a.devolve && !dv_prev) dv_runs++;
    if (bus_a.rejeita) rj_n++;
    dv_prev = bus_a.devolve;
  end

  task automatic chk(string tag, int got, int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr_cnt();
    mo_n = 0;
    dv_n = 0;
    dv_runs = 0;
    rj_n = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  task automatic finish_pay(bit busy, int change);
    tick(change + 3);
    chk("pay_moeda", mo_n, 1);
    chk("pay_devolve", dv_n, change);
    chk("pay_runs", dv_runs, (change > 0) ? 1 : 0);
    chk("pay_cred", int'(bus_a.credito), 0);
    if (busy) begin
      b50 = 1'b1;
      tick(1);
      b50 = 1'b0;
      exp_rej++;
      chk("busy_cred", int'(bus_a.credito), 0);
      tick(2);
      ocup = 1'b0;
    end
    tick(3);
    chk("pay_rej", rj_n, exp_rej);
  endtask

  task automatic finish_refund(int refund);
    tick(refund + 3);
    chk("ref_devolve", dv_n, refund);
    chk("ref_runs", dv_runs, 1);
    chk("ref_moeda", mo_n, 0);
    chk("ref_rej", rj_n, exp_rej);
    chk("ref_cred", int'(bus_a.credito), 0);
  endtask

  task automatic do_coin(int add, bit withc, output bit paid);
    b50 = add[0];
    b1r = add[1];
    canc = withc;
    tick(1);
    canc = 1'b0;
    if (credit + add <= 8) credit += add;
    else exp_rej++;
    chk("coin_cred", int'(bus_a.credito), credit);
    tick($urandom_range(0, 2));
    b50 = 1'b0;
    b1r = 1'b0;
    tick(1);
    paid = (credit >= 4);
  endtask

  task automatic run_ops(bit busy);
    int op, i, refund;
    bit done, paid;
    clr_cnt();
    credit = 0;
    exp_rej = 0;
    done = 0;
    i = 0;
    ocup = busy;
    while (!done) begin
      if (i < ops.size()) op = ops[i];
      else if (credit > 0) op = 4;
      else op = 0;
      i++;
      if (op == 0) begin
        done = 1;
        ocup = 1'b0;
      end else if (op <= 3 || (op == 5 && credit == 0)) begin
        do_coin((op == 5) ? 2 : op, op == 5, paid);
        if (paid) begin
          finish_pay(busy, credit - 4);
          done = 1;
        end
      end else if (op == 4 && credit == 0) begin
        canc = 1'b1;
        tick(1);
        canc = 1'b0;
        chk("idle_cancel_cred", int'(bus_a.credito), 0);
        tick(2);
        chk("idle_cancel_dv", dv_n, 0);
      end else begin
        refund = credit;
        canc = 1'b1;
        b1r = (op == 5);
        tick(1);
        canc = 1'b0;
        b1r = 1'b0;
        if (op == 5) exp_rej++;
        chk("cancel_cred", int'(bus_a.credito), 0);
        credit = 0;
        finish_refund(refund);
        ocup = 1'b0;
        done = 1;
      end
    end
  endtask

  task automatic press(int kind);
    b50 = kind[0];
    b1r = kind[1];
    tick(1);
    b50 = 1'b0;
    b1r = 1'b0;
    tick(1);
  endtask

  initial begin
    int r;
    b50 = 0; b1r = 0; canc = 0; ocup = 0;
    reset = 1'b1;
    tick(2);
    chk("rst_moeda", int'(bus_a.moeda), 0);
    chk("rst_devolve", int'(bus_a.devolve), 0);
    chk("rst_rejeita", int'(bus_a.rejeita), 0);
    chk("rst_cred", int'(bus_a.credito), 0);
    reset = 1'b0;
    tick(2);

    ops = '{2, 2};       run_ops(1);
    ops = '{1, 2, 2};    run_ops(1);
    ops = '{1, 2, 4};    run_ops(0);
    ops = '{3, 4};       run_ops(0);
    ops = '{2, 5};       run_ops(0);
    ops = '{4, 1, 1, 1}; run_ops(0);

    // credit ceiling on the PRECO=8 instance
    do_reset();
    press(2);
    press(2);
    press(2);
    press(1);
    chk("max_cred7", int'(bus_b.credito), 7);
    b1r = 1'b1;
    tick(1);
    chk("max_rej", int'(bus_b.rejeita), 1);
    chk("max_keep", int'(bus_b.credito), 7);
    b1r = 1'b0;
    tick(1);
    chk("max_rej_1cyc", int'(bus_b.rejeita), 0);

    // buttons held high across reset release
    reset = 1'b1;
    b50 = 1'b1;
    b1r = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(3);
    chk("held_cred", int'(bus_a.credito), 0);
    b50 = 1'b0;
    b1r = 1'b0;
    tick(2);

    // reset while returning change
    do_reset();
    press(2);
    press(1);
    chk("mid_cred3", int'(bus_a.credito), 3);
    canc = 1'b1;
    tick(1);
    canc = 1'b0;
    tick(1);
    chk("mid_dv_on", int'(bus_a.devolve), 1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mid_dv_off", int'(bus_a.devolve), 0);
    chk("mid_cred0", int'(bus_a.credito), 0);
    tick(1);
    reset = 1'b0;
    clr_cnt();
    tick(5);
    chk("mid_no_dv", dv_n, 0);
    press(1);
    chk("mid_idle_coin", int'(bus_a.credito), 1);
    canc = 1'b1;
    tick(1);
    canc = 1'b0;
    tick(4);
    do_reset();

    repeat (40) begin
      ops.delete();
      repeat ($urandom_range(1, 4)) begin
        r = $urandom_range(0, 9);
        if (r <= 2) ops.push_back(1);
        else if (r <= 5) ops.push_back(2);
        else if (r == 6) ops.push_back(3);
        else if (r <= 8) ops.push_back(4);
        else ops.push_back(5);
      end
      run_ops(1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_chk, n_fail);
    $finish;
  end

endmodule
